// File: rtl/sram_2p_march_bist.sv
// sram_2p_march_bist: March C- BIST controller for port A of the 2-port SRAM macro.
// Registered SRAM-side outputs, one-cycle read-compare pipeline, sticky pass/fail status.
module sram_2p_march_bist #(
    parameter int                      P_DATA_WIDTH = 20,
    parameter int                      P_ADDR_WIDTH = 9,
    parameter logic [P_DATA_WIDTH-1:0] P_BG         = '0,
    parameter int                      P_CNT_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    output logic                    BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] BIST_BM,
    output logic                    BIST_MEN,
    output logic                    BIST_WEN,
    output logic                    BIST_REN,
    input  logic [P_DATA_WIDTH-1:0] BIST_DOUT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [P_CNT_WIDTH-1:0]  FAIL_CNT
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    state_t                  state, n_state, nxt_elem;
    logic [P_ADDR_WIDTH-1:0] addr, n_addr, cmp_addr;
    logic                    phase, n_phase;
    logic                    two_op, desc, elem_end;
    logic                    n_busy, n_op, n_rd, n_wr, n_done;
    logic [P_DATA_WIDTH-1:0] n_din, cur_exp, cmp_exp;
    logic                    cmp_v, clr;

    // state/addr/phase describe the operation driven on the SRAM pins this cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            addr  <= '0;
            phase <= 1'b0;
        end else begin
            state <= n_state;
            addr  <= n_addr;
            phase <= n_phase;
        end
    end

    always_comb begin
        two_op   = state inside {S_M1, S_M2, S_M3, S_M4};
        desc     = state inside {S_M3, S_M4};
        elem_end = (desc ? (addr == '0) : (addr == '1)) && (!two_op || phase);
        nxt_elem = state_t'(state + 4'd1);
        n_state  = state;
        n_addr   = addr;
        n_phase  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    n_state = S_M0;
                    n_addr  = '0;
                end
            end
            S_DRAIN: n_state = S_DONE;
            default: begin
                if (two_op && !phase) begin
                    n_phase = 1'b1;
                end else if (elem_end) begin
                    n_state = nxt_elem;
                    n_addr  = (nxt_elem == S_M3 || nxt_elem == S_M4) ? '1 : '0;
                end else begin
                    n_addr = desc ? addr - 1'b1 : addr + 1'b1;
                end
            end
        endcase
    end

    // Decode the next cycle's operation so every SRAM-side pin comes straight from a flop
    always_comb begin
        n_busy  = n_state inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN};
        n_op    = n_state inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
        n_rd    = (n_state inside {S_M1, S_M2, S_M3, S_M4} && !n_phase) || n_state == S_M5;
        n_wr    = n_op && !n_rd;
        n_done  = n_state == S_DONE;
        n_din   = n_wr ? ((n_state inside {S_M1, S_M3}) ? ~P_BG : P_BG) : BIST_DIN;
        cur_exp = (state == S_M2 || state == S_M4) ? ~P_BG : P_BG;
        clr     = START && (state == S_IDLE || state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BIST_EN   <= 1'b0;
            BIST_ADDR <= '0;
            BIST_DIN  <= '0;
            BIST_BM   <= '0;
            BIST_MEN  <= 1'b0;
            BIST_WEN  <= 1'b0;
            BIST_REN  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            BIST_EN   <= n_busy;
            BIST_ADDR <= n_op ? n_addr : '0;
            BIST_DIN  <= n_din;
            BIST_BM   <= n_busy ? '1 : '0;
            BIST_MEN  <= n_op;
            BIST_WEN  <= n_wr;
            BIST_REN  <= n_rd;
            BUSY      <= n_busy;
            DONE      <= n_done;
        end
    end

    // Read issued this cycle returns data next cycle; compare it then
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_v     <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_CNT  <= '0;
        end else begin
            cmp_v    <= BIST_REN;
            cmp_exp  <= cur_exp;
            cmp_addr <= BIST_ADDR;
            if (clr) begin
                FAIL      <= 1'b0;
                FAIL_ADDR <= '0;
                FAIL_CNT  <= '0;
            end else if (cmp_v && BIST_DOUT != cmp_exp) begin
                FAIL <= 1'b1;
                if (!FAIL) FAIL_ADDR <= cmp_addr;
                if (FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// tb_sram_2p_march_bist: three controllers on behavioural 4x8 SRAMs (clean, stuck bit at addr 2,
// inverted read data with a 2-bit fail counter), checked against hand-computed March C- vectors.
module tb_sram_2p_march_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic       en [3], men [3], wen [3], ren [3], busy [3], done [3], fail [3];
    logic [1:0] addr [3], fail_addr [3];
    logic [7:0] din [3], bm [3], dout [3];
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int failures = 0;

    sram_2p_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .P_BG(8'h55), .P_CNT_WIDTH(8)) u_a (
        .CLK(clk), .RST_N(rst_n), .START(start), .BIST_EN(en[0]), .BIST_ADDR(addr[0]),
        .BIST_DIN(din[0]), .BIST_BM(bm[0]), .BIST_MEN(men[0]), .BIST_WEN(wen[0]),
        .BIST_REN(ren[0]), .BIST_DOUT(dout[0]), .BUSY(busy[0]), .DONE(done[0]),
        .FAIL(fail[0]), .FAIL_ADDR(fail_addr[0]), .FAIL_CNT(cnt_a));

    sram_2p_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .P_BG(8'h00), .P_CNT_WIDTH(8)) u_b (
        .CLK(clk), .RST_N(rst_n), .START(start), .BIST_EN(en[1]), .BIST_ADDR(addr[1]),
        .BIST_DIN(din[1]), .BIST_BM(bm[1]), .BIST_MEN(men[1]), .BIST_WEN(wen[1]),
        .BIST_REN(ren[1]), .BIST_DOUT(dout[1]), .BUSY(busy[1]), .DONE(done[1]),
        .FAIL(fail[1]), .FAIL_ADDR(fail_addr[1]), .FAIL_CNT(cnt_b));

    sram_2p_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .P_BG(8'h55), .P_CNT_WIDTH(2)) u_c (
        .CLK(clk), .RST_N(rst_n), .START(start), .BIST_EN(en[2]), .BIST_ADDR(addr[2]),
        .BIST_DIN(din[2]), .BIST_BM(bm[2]), .BIST_MEN(men[2]), .BIST_WEN(wen[2]),
        .BIST_REN(ren[2]), .BIST_DOUT(dout[2]), .BUSY(busy[2]), .DONE(done[2]),
        .FAIL(fail[2]), .FAIL_ADDR(fail_addr[2]), .FAIL_CNT(cnt_c));

    // Behavioural SRAMs: write captured at the edge, read data presented the following cycle
    logic [7:0] mem [3][4];
    logic [7:0] rd [3];
    logic [1:0] raddr [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (men[i] && wen[i]) mem[i][addr[i]] <= (mem[i][addr[i]] & ~bm[i]) | (din[i] & bm[i]);
            if (men[i] && ren[i]) begin
                rd[i]    <= mem[i][addr[i]];
                raddr[i] <= addr[i];
            end
        end
    end

    assign dout[0] = rd[0];
    assign dout[1] = rd[1] | {7'd0, raddr[1] == 2'd2};
    assign dout[2] = ~rd[2];

    typedef struct {
        int          cyc;
        logic [23:0] exp;
        logic [23:0] msk;
    } vec_t;

    vec_t vt[$];

    localparam logic [23:0] ALL   = 24'hFFFFFF;
    localparam logic [23:0] NOADR = 24'hF3FFFF;
    localparam logic [23:0] NOEN  = 24'h73FFFF;

    function automatic logic [23:0] mk(input logic e, input logic m, input logic w, input logic r,
                                       input logic [1:0] a, input logic [7:0] d,
                                       input logic b, input logic dn);
        return {e, m, w, r, a, d, b ? 8'hFF : 8'h00, b, dn};
    endfunction

    function automatic logic [23:0] pk(input int i);
        return {en[i], men[i], wen[i], ren[i], addr[i], din[i], bm[i], busy[i], done[i]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // START at edge 0, then walk cycles 1..upto; optional extra START pulse during pulse_cyc
    task automatic run(input int upto, input bit use_tbl, input int pulse_cyc);
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= upto; c++) begin
            if (c == 1) begin
                chk("start_busy", {31'd0, busy[0]}, 1);
                chk("start_done", {31'd0, done[0]}, 0);
                chk("start_clr_fail_b", {31'd0, fail[1]}, 0);
                chk("start_clr_cnt_b", {24'd0, cnt_b}, 0);
                chk("start_clr_addr_b", {30'd0, fail_addr[1]}, 0);
                chk("start_clr_cnt_c", {30'd0, cnt_c}, 0);
            end
            if (use_tbl) begin
                while (k < vt.size() && vt[k].cyc == c) begin
                    chk($sformatf("vec_c%0d", c), {8'd0, pk(0) & vt[k].msk}, {8'd0, vt[k].exp & vt[k].msk});
                    k++;
                end
            end
            if (c == 41) chk("busy_c41", {30'd0, busy[0], done[0]}, 32'd2);
            if (c == 42) chk("done_c42", {30'd0, busy[0], done[0]}, 32'd1);
            if (c < upto) begin
                if (c == pulse_cyc) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        vt.push_back('{1,  mk(1, 1, 1, 0, 2'd0, 8'h55, 1, 0), ALL});
        vt.push_back('{4,  mk(1, 1, 1, 0, 2'd3, 8'h55, 1, 0), ALL});
        vt.push_back('{5,  mk(1, 1, 0, 1, 2'd0, 8'h55, 1, 0), ALL});
        vt.push_back('{6,  mk(1, 1, 1, 0, 2'd0, 8'hAA, 1, 0), ALL});
        vt.push_back('{7,  mk(1, 1, 0, 1, 2'd1, 8'hAA, 1, 0), ALL});
        vt.push_back('{12, mk(1, 1, 1, 0, 2'd3, 8'hAA, 1, 0), ALL});
        vt.push_back('{13, mk(1, 1, 0, 1, 2'd0, 8'hAA, 1, 0), ALL});
        vt.push_back('{14, mk(1, 1, 1, 0, 2'd0, 8'h55, 1, 0), ALL});
        vt.push_back('{21, mk(1, 1, 0, 1, 2'd3, 8'h55, 1, 0), ALL});
        vt.push_back('{22, mk(1, 1, 1, 0, 2'd3, 8'hAA, 1, 0), ALL});
        vt.push_back('{28, mk(1, 1, 1, 0, 2'd0, 8'hAA, 1, 0), ALL});
        vt.push_back('{29, mk(1, 1, 0, 1, 2'd3, 8'hAA, 1, 0), ALL});
        vt.push_back('{30, mk(1, 1, 1, 0, 2'd3, 8'h55, 1, 0), ALL});
        vt.push_back('{36, mk(1, 1, 1, 0, 2'd0, 8'h55, 1, 0), ALL});
        vt.push_back('{37, mk(1, 1, 0, 1, 2'd0, 8'h55, 1, 0), ALL});
        vt.push_back('{40, mk(1, 1, 0, 1, 2'd3, 8'h55, 1, 0), ALL});
        vt.push_back('{41, mk(0, 0, 0, 0, 2'd0, 8'h55, 1, 0), NOEN});
        vt.push_back('{42, mk(0, 0, 0, 0, 2'd0, 8'h55, 0, 1), NOADR});

        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_pins%0d", i), {8'd0, pk(i)}, 0);
            chk($sformatf("reset_stat%0d", i), {29'd0, fail[i], fail_addr[i]}, 0);
        end
        chk("reset_cnt", {14'd0, cnt_a, cnt_b, cnt_c}, 0);
        rst_n = 1'b1;
        tick();

        run(42, 1'b1, 0);
        chk("clean_fail", {31'd0, fail[0]}, 0);
        chk("clean_cnt", {24'd0, cnt_a}, 0);
        for (int j = 0; j < 4; j++) chk($sformatf("clean_mem%0d", j), {24'd0, mem[0][j]}, 32'h55);
        chk("stuck_fail", {31'd0, fail[1]}, 1);
        chk("stuck_addr", {30'd0, fail_addr[1]}, 2);
        chk("stuck_cnt", {24'd0, cnt_b}, 3);
        chk("sat_fail", {31'd0, fail[2]}, 1);
        chk("sat_addr", {30'd0, fail_addr[2]}, 0);
        chk("sat_cnt", {30'd0, cnt_c}, 3);

        run(42, 1'b1, 10);
        chk("rerun_stuck_cnt", {24'd0, cnt_b}, 3);
        chk("rerun_stuck_addr", {30'd0, fail_addr[1]}, 2);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        chk("pre_reset_busy", {31'd0, busy[0]}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", {27'd0, en[0], busy[0], men[0], wen[0], ren[0]}, 0);
        chk("async_rst_b", {27'd0, en[1], busy[1], men[1], wen[1], ren[1]}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {30'd0, busy[0], done[0]}, 0);
        run(42, 1'b0, 0);
        chk("after_rst_fail", {31'd0, fail[0]}, 0);
        chk("after_rst_stuck_cnt", {24'd0, cnt_b}, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_2p_march_bist.md
Name: sram_2p_march_bist

Overview:
- March C- BIST controller that drives the port-A BIST interface of the 2-port SRAM macro: A_BIST_EN/ADDR/DIN/BM/MEN/WEN/REN. A_BIST_CLK is tied to CLK at top level.
- Reads back A_DOUT, compares it against expected data and reports pass/fail status to the test/control logic.
- Sits directly upstream of the SRAM BIST mux; port B is not exercised.

Parameters:
- P_DATA_WIDTH, 20, SRAM word width.
- P_ADDR_WIDTH, 9, SRAM address width; N = 2^P_ADDR_WIDTH words.
- P_BG, {P_DATA_WIDTH{1'b0}}, data background. "w0" writes P_BG; "w1" writes ~P_BG.
- P_CNT_WIDTH, 8, width of the saturating fail counter.

Ports:
- CLK  in  1  controller clock; also drives the SRAM A_BIST_CLK.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  single-cycle start request, sampled on the rising edge of CLK.
- BIST_EN  out  1  drives A_BIST_EN.
- BIST_ADDR  out  P_ADDR_WIDTH  drives A_BIST_ADDR.
- BIST_DIN  out  P_DATA_WIDTH  drives A_BIST_DIN.
- BIST_BM  out  P_DATA_WIDTH  drives A_BIST_BM.
- BIST_MEN  out  1  drives A_BIST_MEN.
- BIST_WEN  out  1  drives A_BIST_WEN.
- BIST_REN  out  1  drives A_BIST_REN.
- BIST_DOUT  in  P_DATA_WIDTH  from A_DOUT.
- BUSY  out  1  test running.
- DONE  out  1  test finished; sticky until next START or reset.
- FAIL  out  1  at least one miscompare; sticky.
- FAIL_ADDR  out  P_ADDR_WIDTH  address of the first miscompare.
- FAIL_CNT  out  P_CNT_WIDTH  miscompare count, saturates at all-ones.

Behaviour:
- Reset (asynchronous, RST_N=0): state IDLE.
  - All outputs 0, including BIST_EN, BIST_BM, FAIL_ADDR and FAIL_CNT.
  - Compare pipeline flushed.
  - Reset mid-test aborts immediately; BIST_EN drops without waiting for a clock.
- All SRAM-side outputs are registered. An operation driven in cycle k is captured by the SRAM at the edge ending cycle k.
- Read data is valid on BIST_DOUT in cycle k+1. The compare happens at the edge ending cycle k+1.
- States: IDLE -> M0 -> M1 -> M2 -> M3 -> M4 -> M5 -> DRAIN -> DONE.
  - M0: ascending address, w0.
  - M1: ascending, r0 then w1.
  - M2: ascending, r1 then w0.
  - M3: descending, r0 then w1.
  - M4: descending, r1 then w0.
  - M5: ascending, r0.
- One SRAM operation per cycle, no idle cycles between elements.
  - Two-op elements use a phase bit: the read cycle is followed by the write cycle at the same address.
  - Total operation cycles: 10N.
- Operation encoding:
  - Read: MEN=1, REN=1, WEN=0.
  - Write: MEN=1, WEN=1, REN=0.
  - BIST_BM is all-ones while BUSY=1.
  - BIST_DIN = P_BG or ~P_BG during writes, and holds its last value during reads.
- Addressing:
  - Ascending elements start at 0 and end at N-1.
  - Descending elements start at N-1 and end at 0.
  - An element transitions when its final op at the terminal address completes. The counter wraps with no extra cycle.
- Start:
  - START in IDLE or DONE clears DONE, FAIL, FAIL_ADDR and FAIL_CNT, sets BUSY and BIST_EN, and enters M0.
  - If START is sampled at edge 0, the first op is in cycle 1.
  - START while BUSY=1 is ignored.
- Compare stage:
  - Each read registers {valid, expected, address}; the next cycle compares BIST_DOUT against expected.
  - On a mismatch:
    - FAIL is set.
    - FAIL_CNT is incremented unless saturated.
    - FAIL_ADDR is loaded only if FAIL was 0 before this compare.
  - A write-only cycle produces no compare.
- DRAIN:
  - Entered after the last M5 read. All SRAM-side enables are 0.
  - Lasts 1 cycle for the final compare, then moves to DONE.
  - The last op is in cycle 10N, its compare at the end of cycle 10N+1, and DONE=1 from cycle 10N+2.
- DONE state: BUSY=0, BIST_EN=0, MEN=WEN=REN=0. Status holds.
- BUSY=1 from M0 through DRAIN inclusive.

Test Plan:
- Clean pass. P_ADDR_WIDTH=2, P_DATA_WIDTH=8, P_BG=8'h55; START at edge 0.
  - Ops in cycles 1..40; DONE=1 in cycle 42; FAIL=0, FAIL_CNT=0.
  - Final memory content = 8'h55 at all 4 addresses.
- Sequence check, same configuration.
  - Cycles 1-4: writes 55 to addr 0,1,2,3.
  - Cycle 5: read addr 0. Cycle 6: write AA to addr 0.
  - Cycle 21: read addr 3 (start of M3, descending).
  - BIST_BM=8'hFF throughout.
- Stuck-at fault: bench forces bit 0 of BIST_DOUT to 1 on every response from addr 2.
  - FAIL=1 and FAIL_ADDR=2.
  - FAIL_CNT=3: the r0 responses in M1, M3 and M5 each miscompare.
- Saturation: P_CNT_WIDTH=2, bench inverts every BIST_DOUT.
  - FAIL_CNT=3 at DONE.
  - FAIL_ADDR=0, from the first read in M1.
- Reset mid-test: RST_N=0 in cycle 15.
  - BIST_EN, BUSY, MEN, WEN and REN go to 0 before the next edge.
  - After release, START reruns a full test with DONE at START+42.
- START while BUSY (cycle 10) is ignored and DONE timing is unchanged. START in DONE clears FAIL and FAIL_CNT and restarts M0.
